// File: rtl/tx_tdm_serializer.sv
// Multi-channel serial audio transmitter (I2S, left-justified or TDM).
// A big-endian byte stream is assembled into complete frames (double
// buffered against the shift buffer) and serialised with bclk/lrck derived
// from clk_i. Missing frames are zero-filled; after IDLE_FRAMES zero frames,
// or when enable_i drops, the stream stops after one extra bclk period.
//
// Ports:
//   clk_i, reset_n_i      clock, synchronous active-low reset
//   enable_i              streaming permitted
//   mode_i                0=I2S, 1=LJ, 2=TDM, 3=I2S
//   bit_depth_i           0=16, 1=24, 2=32, 3=DoP (2/3/4/3 bytes per sample)
//   bclk_half_i           clk cycles per bclk half period (0 acts as 1)
//   s_data_i/s_valid_i/s_ready_o   byte stream input, MSB byte first
//   streaming_o           serialising (RUN or DRAIN)
//   underrun_o            one-clk pulse at each zero-filled frame start
//   sdata_o, bclk_o, lrck_o        serial audio outputs
module tx_tdm_serializer #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned SLOT_BITS   = 32,
  parameter int unsigned IDLE_FRAMES = 4
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       enable_i,
  input  logic [1:0] mode_i,
  input  logic [1:0] bit_depth_i,
  input  logic [7:0] bclk_half_i,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  output logic       streaming_o,
  output logic       underrun_o,
  output logic       sdata_o,
  output logic       bclk_o,
  output logic       lrck_o
);

  localparam int unsigned FrameBits = CHANNELS * SLOT_BITS;
  localparam int unsigned KW        = $clog2(FrameBits);
  localparam int unsigned CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  // Bytes that actually land in a slot; extra bytes of wide samples are dropped.
  localparam int unsigned SlotBytes = (SLOT_BITS / 8 < 4) ? SLOT_BITS / 8 : 4;
  localparam logic [KW-1:0] KLast   = KW'(FrameBits - 1);
  localparam logic [1:0] ModeLj     = 2'd1;
  localparam logic [1:0] ModeTdm    = 2'd2;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [1:0]             last_byte_q, last_byte_d;
  logic [7:0]             half_q, half_d;
  logic [7:0]             hcnt_q, hcnt_d;
  logic [KW-1:0]          k_q, k_d;
  logic                   bclk_q, bclk_d;
  logic                   lrck_q, lrck_d;
  logic                   sdata_q, sdata_d;
  logic                   under_q, under_d;
  logic [3:0]             ucnt_q, ucnt_d;
  logic [FrameBits-1:0]   asm_q, asm_d;
  logic [FrameBits-1:0]   sh_q, sh_d;
  logic [CW-1:0]          asm_ch_q, asm_ch_d;
  logic [1:0]             asm_byte_q, asm_byte_d;
  logic                   asm_full_q, asm_full_d;

  logic       load, accept, bclk_term, delayed;
  logic [1:0] cur_last;

  // Frame bit k of a buffer; slot 0 occupies the top of the vector.
  function automatic logic bit_of(input logic [FrameBits-1:0] v, input logic [KW-1:0] k);
    return v[KLast - k];
  endfunction

  function automatic logic lrck_for(input logic [1:0] m, input logic [KW-1:0] k);
    if (m == ModeLj)       return k < KW'(SLOT_BITS);
    else if (m == ModeTdm) return k == '0;
    else                   return k >= KW'(SLOT_BITS);
  endfunction

  function automatic logic [1:0] last_byte_for(input logic [1:0] depth);
    unique case (depth)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      2'd2:    return 2'd3;
      default: return 2'd2;
    endcase
  endfunction

  assign s_ready_o   = reset_n_i & enable_i & (state_q != StDrain) & ~asm_full_q;
  assign accept      = s_valid_i & s_ready_o;
  assign bclk_term   = (hcnt_q == half_q - 8'd1);
  assign delayed     = (mode_q != ModeLj);
  // Before the stream starts the live depth applies; afterwards the latched one.
  assign cur_last    = (state_q == StIdle) ? last_byte_for(bit_depth_i) : last_byte_q;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    last_byte_d = last_byte_q;
    half_d      = half_q;
    hcnt_d      = hcnt_q;
    k_d         = k_q;
    bclk_d      = bclk_q;
    lrck_d      = lrck_q;
    sdata_d     = sdata_q;
    under_d     = 1'b0;
    ucnt_d      = ucnt_q;
    asm_d       = asm_q;
    sh_d        = sh_q;
    asm_ch_d    = asm_ch_q;
    asm_byte_d  = asm_byte_q;
    asm_full_d  = asm_full_q;
    load        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (asm_full_q && enable_i) begin
          state_d     = StRun;
          mode_d      = mode_i;
          last_byte_d = last_byte_for(bit_depth_i);
          half_d      = (bclk_half_i == 8'd0) ? 8'd1 : bclk_half_i;
          load        = 1'b1;
          sh_d        = asm_q;
          ucnt_d      = '0;
          hcnt_d      = '0;
          k_d         = '0;
          bclk_d      = 1'b0;
          lrck_d      = lrck_for(mode_i, '0);
          // First frame: the delayed formats have no previous bit to emit.
          sdata_d     = (mode_i == ModeLj) ? asm_q[FrameBits-1] : 1'b0;
        end
      end
      StRun: begin
        if (!bclk_term) begin
          hcnt_d = hcnt_q + 8'd1;
        end else begin
          hcnt_d = '0;
          if (!bclk_q) begin
            bclk_d = 1'b1;
          end else begin
            bclk_d = 1'b0;
            if (k_q == KLast) begin
              k_d = '0;
              if (!enable_i || (!asm_full_q && ucnt_q == 4'(IDLE_FRAMES))) begin
                state_d = StDrain;
                lrck_d  = 1'b0;
                sdata_d = delayed ? bit_of(sh_q, KLast) : 1'b0;
              end else begin
                if (asm_full_q) begin
                  load   = 1'b1;
                  sh_d   = asm_q;
                  ucnt_d = '0;
                end else begin
                  sh_d    = '0;
                  under_d = 1'b1;
                  ucnt_d  = ucnt_q + 4'd1;
                end
                lrck_d  = lrck_for(mode_q, '0);
                sdata_d = delayed ? bit_of(sh_q, KLast) : bit_of(sh_d, '0);
              end
            end else begin
              k_d     = k_q + KW'(1);
              lrck_d  = lrck_for(mode_q, k_d);
              sdata_d = delayed ? bit_of(sh_q, k_q) : bit_of(sh_q, k_d);
            end
          end
        end
      end
      StDrain: begin
        if (!bclk_term) begin
          hcnt_d = hcnt_q + 8'd1;
        end else begin
          hcnt_d = '0;
          if (!bclk_q) begin
            bclk_d = 1'b1;
          end else begin
            state_d    = StIdle;
            lrck_d     = 1'b0;
            sdata_d    = 1'b0;
            ucnt_d     = '0;
            asm_ch_d   = '0;
            asm_byte_d = '0;
            asm_full_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A byte arriving with a frame load starts the freshly cleared buffer.
    if (load) begin
      asm_ch_d   = '0;
      asm_byte_d = '0;
      asm_full_d = 1'b0;
    end
    if (accept) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (asm_ch_d == CW'(c)) begin
          // Clearing on the first byte provides the LSB zero padding.
          if (asm_byte_d == 2'd0) asm_d[FrameBits-1-c*SLOT_BITS -: SLOT_BITS] = '0;
          for (int b = 0; b < SlotBytes; b++) begin
            if (asm_byte_d == 2'(b)) asm_d[FrameBits-1-c*SLOT_BITS-8*b -: 8] = s_data_i;
          end
        end
      end
      if (asm_byte_d == cur_last) begin
        asm_byte_d = '0;
        if (asm_ch_d == CW'(CHANNELS - 1)) begin
          asm_ch_d   = '0;
          asm_full_d = 1'b1;
        end else begin
          asm_ch_d = asm_ch_d + CW'(1);
        end
      end else begin
        asm_byte_d = asm_byte_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= StIdle;
      mode_q      <= '0;
      last_byte_q <= 2'd1;
      half_q      <= 8'd1;
      hcnt_q      <= '0;
      k_q         <= '0;
      bclk_q      <= 1'b1;
      lrck_q      <= 1'b0;
      sdata_q     <= 1'b0;
      under_q     <= 1'b0;
      ucnt_q      <= '0;
      asm_ch_q    <= '0;
      asm_byte_q  <= '0;
      asm_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      last_byte_q <= last_byte_d;
      half_q      <= half_d;
      hcnt_q      <= hcnt_d;
      k_q         <= k_d;
      bclk_q      <= bclk_d;
      lrck_q      <= lrck_d;
      sdata_q     <= sdata_d;
      under_q     <= under_d;
      ucnt_q      <= ucnt_d;
      asm_ch_q    <= asm_ch_d;
      asm_byte_q  <= asm_byte_d;
      asm_full_q  <= asm_full_d;
    end
  end

  // Sample data needs no reset; validity is tracked by the counters above.
  always_ff @(posedge clk_i) begin
    asm_q <= asm_d;
    sh_q  <= sh_d;
  end

  assign streaming_o = (state_q != StIdle);
  assign underrun_o  = under_q;
  assign sdata_o     = sdata_q;
  assign bclk_o      = bclk_q;
  assign lrck_o      = lrck_q;

endmodule

// File: tb/tb_tx_tdm_serializer.sv
// Directed bench: stereo instance for I2S/LJ/underrun/enable/reset cases and
// a 4-channel instance for TDM. Serial bits are captured on each bclk rise.
module tb_tx_tdm_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_a = 1'b0;
  logic [1:0] mode_a = 2'd0;
  logic [1:0] bd_a = 2'd0;
  logic [7:0] half_a = 8'd2;
  logic [7:0] data_a = 8'd0;
  logic       valid_a = 1'b0;
  logic       ready_a, strm_a, ur_a, sd_a, bclk_a, lr_a;
  logic       en_b = 1'b0;
  logic [7:0] data_b = 8'd0;
  logic       valid_b = 1'b0;
  logic       ready_b, strm_b, ur_b, sd_b, bclk_b, lr_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ur_cnt_a = 0;
  bit cap_sd_a[$];
  bit cap_lr_a[$];
  int cap_t_a[$];
  bit cap_sd_b[$];
  bit cap_lr_b[$];
  logic [255:0] e;

  tx_tdm_serializer #(.CHANNELS(2), .SLOT_BITS(32), .IDLE_FRAMES(4)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .enable_i(en_a), .mode_i(mode_a),
    .bit_depth_i(bd_a), .bclk_half_i(half_a), .s_data_i(data_a), .s_valid_i(valid_a),
    .s_ready_o(ready_a), .streaming_o(strm_a), .underrun_o(ur_a), .sdata_o(sd_a),
    .bclk_o(bclk_a), .lrck_o(lr_a)
  );

  tx_tdm_serializer #(.CHANNELS(4), .SLOT_BITS(32), .IDLE_FRAMES(4)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .enable_i(en_b), .mode_i(2'd2),
    .bit_depth_i(2'd2), .bclk_half_i(8'd1), .s_data_i(data_b), .s_valid_i(valid_b),
    .s_ready_o(ready_b), .streaming_o(strm_b), .underrun_o(ur_b), .sdata_o(sd_b),
    .bclk_o(bclk_b), .lrck_o(lr_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ur_a) ur_cnt_a <= ur_cnt_a + 1;
  end

  always @(posedge bclk_a) begin
    cap_sd_a.push_back(sd_a);
    cap_lr_a.push_back(lr_a);
    cap_t_a.push_back(cyc);
  end

  always @(posedge bclk_b) begin
    cap_sd_b.push_back(sd_b);
    cap_lr_b.push_back(lr_b);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // Captured bits start..start+n-1, first bit at the MSB of the n-bit result.
  function automatic logic [255:0] pack(input bit q[$], input int start, input int n);
    logic [255:0] r = '0;
    for (int i = 0; i < n; i++) r = {r[254:0], (start + i < q.size()) ? q[start + i] : 1'b0};
    return r;
  endfunction

  function automatic int ones(input bit q[$], input int start, input int n);
    int c = 0;
    for (int i = start; i < start + n && i < q.size(); i++) c += int'(q[i]);
    return c;
  endfunction

  task automatic clear_caps();
    cap_sd_a.delete(); cap_lr_a.delete(); cap_t_a.delete();
    cap_sd_b.delete(); cap_lr_b.delete();
    ur_cnt_a = 0;
  endtask

  task automatic put_a(input logic [7:0] b);
    int n = 0;
    @(negedge clk); data_a = b; valid_a = 1'b1;
    while (!ready_a && n < 4000) begin @(negedge clk); n++; end
    if (n >= 4000) check("put_a_timeout", 256'(ready_a), 256'd1);
    @(posedge clk); #1; valid_a = 1'b0;
  endtask

  task automatic put_b(input logic [7:0] b);
    int n = 0;
    @(negedge clk); data_b = b; valid_b = 1'b1;
    while (!ready_b && n < 4000) begin @(negedge clk); n++; end
    if (n >= 4000) check("put_b_timeout", 256'(ready_b), 256'd1);
    @(posedge clk); #1; valid_b = 1'b0;
  endtask

  task automatic wait_strm_a(input logic level, input string tag);
    int n = 0;
    while (strm_a !== level && n < 20000) begin @(posedge clk); n++; end
    check(tag, 256'(strm_a), 256'(level));
  endtask

  task automatic wait_cap_a(input int cnt, input string tag);
    int n = 0;
    while (cap_sd_a.size() < cnt && n < 20000) begin @(posedge clk); n++; end
    check(tag, 256'(cap_sd_a.size() >= cnt), 256'd1);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_bclk", 256'(bclk_a), 256'd1);
    check("rst_lrck", 256'(lr_a), 256'd0);
    check("rst_sdata", 256'(sd_a), 256'd0);
    check("rst_ready", 256'(ready_a), 256'd0);
    check("rst_streaming", 256'(strm_a), 256'd0);
    check("rst_underrun", 256'(ur_a), 256'd0);
    check("rst_bclk_tdm", 256'(bclk_b), 256'd1);
    @(negedge clk) rst_n = 1'b1;

    // I2S 24-bit, H=2, one frame then underrun zero frames and drain
    mode_a = 2'd0; bd_a = 2'd1; half_a = 8'd2; en_a = 1'b1;
    clear_caps();
    put_a(8'h12); put_a(8'h34); put_a(8'h56); put_a(8'hAB); put_a(8'hCD); put_a(8'hEF);
    wait_strm_a(1'b1, "i2s_start");
    mode_a = 2'd1; half_a = 8'd1;  // must not affect the running stream
    wait_strm_a(1'b0, "i2s_stop");
    @(negedge clk);
    e = 256'h12345600_ABCDEF00;
    check("i2s_cap_count", 256'(cap_sd_a.size()), 256'd321);
    check("i2s_f0_data", pack(cap_sd_a, 0, 64), e >> 1);
    check("i2s_f0_lrck", pack(cap_lr_a, 0, 64), 256'h00000000_FFFFFFFF);
    check("i2s_zero_fill", 256'(ones(cap_sd_a, 64, 257)), 256'd0);
    check("i2s_f4_lrck", pack(cap_lr_a, 256, 64), 256'h00000000_FFFFFFFF);
    check("i2s_drain_lrck", 256'(cap_lr_a[320]), 256'd0);
    check("i2s_bclk_period", 256'(cap_t_a[200] - cap_t_a[199]), 256'd4);
    check("i2s_underruns", 256'(ur_cnt_a), 256'd4);
    check("idle_bclk", 256'(bclk_a), 256'd1);
    check("idle_lrck", 256'(lr_a), 256'd0);
    check("idle_sdata", 256'(sd_a), 256'd0);

    // Left-justified 16-bit, H=1, enable dropped during the frame
    mode_a = 2'd1; bd_a = 2'd0; half_a = 8'd1;
    clear_caps();
    @(negedge clk);
    check("lj_ready_idle", 256'(ready_a), 256'd1);
    put_a(8'h80); put_a(8'h01); put_a(8'h7F); put_a(8'hFE);
    wait_strm_a(1'b1, "lj_start");
    @(negedge clk) en_a = 1'b0;
    #1 check("lj_ready_drop", 256'(ready_a), 256'd0);
    wait_strm_a(1'b0, "lj_stop");
    @(negedge clk);
    check("lj_cap_count", 256'(cap_sd_a.size()), 256'd65);
    check("lj_data", pack(cap_sd_a, 0, 64), 256'h80010000_7FFE0000);
    check("lj_lrck", pack(cap_lr_a, 0, 64), 256'hFFFFFFFF_00000000);
    check("lj_drain_bit", 256'({cap_lr_a[64], cap_sd_a[64]}), 256'd0);

    // I2S 32-bit, enable dropped mid-frame with the next frame complete
    mode_a = 2'd0; bd_a = 2'd2; half_a = 8'd1; en_a = 1'b1;
    clear_caps();
    for (int i = 1; i <= 7; i++) put_a(8'(i));
    put_a(8'h09);
    for (int i = 0; i < 8; i++) put_a(8'(8'h11 + i));
    wait_cap_a(41, "drop_reach_k40");
    @(negedge clk) en_a = 1'b0;
    wait_strm_a(1'b0, "drop_stop");
    @(negedge clk);
    e = 256'h01020304_05060709;
    check("drop_cap_count", 256'(cap_sd_a.size()), 256'd65);
    check("drop_data", pack(cap_sd_a, 0, 64), e >> 1);
    check("drop_final_bit", 256'(cap_sd_a[64]), 256'd1);
    en_a = 1'b1;
    repeat (3) @(negedge clk);
    check("drop_asm_cleared", 256'(ready_a), 256'd1);
    check("drop_no_restart", 256'(strm_a), 256'd0);

    // Reset at k=40 then a clean restart
    mode_a = 2'd0; bd_a = 2'd0; half_a = 8'd2;
    clear_caps();
    put_a(8'h11); put_a(8'h22); put_a(8'h33); put_a(8'h44); put_a(8'h55); put_a(8'h66);
    wait_cap_a(41, "rst_reach_k40");
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_bclk", 256'(bclk_a), 256'd1);
    check("mid_rst_lrck", 256'(lr_a), 256'd0);
    check("mid_rst_sdata", 256'(sd_a), 256'd0);
    check("mid_rst_streaming", 256'(strm_a), 256'd0);
    check("mid_rst_ready", 256'(ready_a), 256'd0);
    @(negedge clk) rst_n = 1'b1;
    clear_caps();
    put_a(8'hA5); put_a(8'h5A); put_a(8'h3C); put_a(8'hC3);
    wait_strm_a(1'b1, "restart_start");
    @(negedge clk) en_a = 1'b0;
    wait_strm_a(1'b0, "restart_stop");
    @(negedge clk);
    e = 256'hA55A0000_3CC30000;
    check("restart_cap_count", 256'(cap_sd_a.size()), 256'd65);
    check("restart_data", pack(cap_sd_a, 0, 64), e >> 1);
    check("restart_lrck", pack(cap_lr_a, 0, 64), 256'h00000000_FFFFFFFF);

    // TDM, 4 channels, 32-bit, two frames then enable dropped
    clear_caps();
    en_b = 1'b1;
    for (int i = 0; i < 32; i++) put_b(8'(8'h10 + i));
    begin
      int n = 0;
      while (cap_sd_b.size() < 140 && n < 20000) begin @(posedge clk); n++; end
      check("tdm_reach_f2", 256'(cap_sd_b.size() >= 140), 256'd1);
    end
    @(negedge clk) en_b = 1'b0;
    begin
      int n = 0;
      while (strm_b && n < 20000) begin @(posedge clk); n++; end
      check("tdm_stop", 256'(strm_b), 256'd0);
    end
    @(negedge clk);
    e = 256'h10111213_14151617_18191A1B_1C1D1E1F_20212223_24252627_28292A2B_2C2D2E2F;
    check("tdm_cap_count", 256'(cap_sd_b.size()), 256'd257);
    check("tdm_data", pack(cap_sd_b, 0, 256), e >> 1);
    check("tdm_fsync", pack(cap_lr_b, 0, 256), (256'd1 << 255) | (256'd1 << 127));
    check("tdm_final_bit", 256'({cap_lr_b[256], cap_sd_b[256]}), 256'd1);
    check("tdm_idle_bclk", 256'(bclk_b), 256'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_tdm_serializer.md
Name: tx_tdm_serializer

Overview:
- Parametrised single-clock successor to the stereo I2S transmitter.
- Accepts a big-endian byte stream, assembles complete multi-channel frames and serialises them as I2S, left-justified or TDM.
- Generates bclk/lrck internally from clk_i.
- Sits between the USB FIFO read side and the DAC pins; provides double-buffered frames, underrun zero-fill and a graceful stop.

Parameters:
CHANNELS, 2, slots per frame (I2S/LJ modes require 2; TDM allows 2..16)
SLOT_BITS, 32, bclk periods per slot (16 or 32); samples shorter than the slot are zero-padded at the LSB end
IDLE_FRAMES, 4, consecutive underrun frames before streaming stops (1..15)

Ports:
clk_i  in  1  system clock; all logic on rising edge
reset_n_i  in  1  synchronous reset, active low
enable_i  in  1  streaming permitted
mode_i  in  2  0=I2S, 1=left-justified, 2=TDM, 3=reserved (treated as I2S)
bit_depth_i  in  2  BIT_DEPTH_16/24/32/DOP codes; bytes per sample 2/3/4/3
bclk_half_i  in  8  clk cycles per bclk half period, >=1 (0 treated as 1)
s_data_i  in  8  sample byte, MSB byte first, channel 0 first
s_valid_i  in  1  byte valid
s_ready_o  out  1  byte accepted when s_valid_i & s_ready_o
streaming_o  out  1  high while serialising (RUN/DRAIN)
underrun_o  out  1  one-clk pulse at each zero-filled frame start
sdata_o  out  1  serial data
bclk_o  out  1  bit clock; idle high
lrck_o  out  1  word clock (I2S/LJ) or frame sync (TDM); idle low

Behaviour:
- Reset (reset_n_i=0 at a clk edge): bclk_o=1, lrck_o=0, sdata_o=0, s_ready_o=0, streaming_o=0, underrun_o=0; state IDLE; assembly and shift buffers marked empty; underrun counter=0.
- mode_i, bit_depth_i and bclk_half_i are latched on the IDLE->RUN transition; changes while streaming are ignored.
- Assembly buffer:
  - Holds CHANNELS samples.
  - s_ready_o = enable_i & state!=DRAIN & assembly buffer not complete.
  - Accepted bytes fill channel c, byte b in order; a sample is left-aligned to bit SLOT_BITS-1.
  - With SLOT_BITS=16, a 24/32-bit sample keeps its top 16 bits.
  - The buffer is complete after CHANNELS*bytes_per_sample accepts.
- States:
  - IDLE -> RUN when the assembly buffer is complete and enable_i=1. The frame is copied to the shift buffer, the assembly buffer is cleared, and bclk_o is driven 0 in the same cycle as frame bit k=0.
  - RUN: bclk half-period counter counts 0..H-1, where H = latched bclk_half_i. At terminal count bclk_o toggles. On every 1->0 edge, sdata_o and lrck_o update for the next bit k. Data never changes on the rising edge.
  - Frame bit k runs 0..CHANNELS*SLOT_BITS-1 and d(k) = shift-buffer bit for slot k/SLOT_BITS, bit SLOT_BITS-1-(k mod SLOT_BITS).
    - I2S: sdata_o=d(k-1) (one-bit delay); lrck_o=(k>=SLOT_BITS).
    - LJ: sdata_o=d(k); lrck_o=(k<SLOT_BITS).
    - TDM: sdata_o=d(k-1); lrck_o=(k==0).
    - d(-1) is the last bit of the previous frame, or 0 for the first frame.
  - Frame boundary (falling edge where k wraps to 0):
    - If the assembly buffer is complete: load it into the shift buffer and clear the underrun counter.
    - Else: the shift buffer becomes all zeros, underrun_o pulses for 1 clk, and the underrun counter increments. A partial assembly is retained.
    - When the counter reaches IDLE_FRAMES, or enable_i=0 at the boundary: go to DRAIN.
  - DRAIN: serialise one extra bclk period, so the delayed final bit (I2S/TDM) is emitted. Then bclk_o=1, lrck_o=0, sdata_o=0, streaming_o=0; clear the partial assembly; go to IDLE.
- Byte accept and frame load in the same clk: the load uses the completed buffer; the new byte goes to the freshly cleared buffer at channel 0, byte 0.
- Reset mid-frame aborts immediately to reset values; partial data is discarded.

Test Plan:
- I2S, CHANNELS=2, SLOT_BITS=32, 24-bit, H=2, bytes 12 34 56 AB CD EF -> lrck_o falls at frame start. sdata_o carries 0 then 0x123456 MSB-first then 8 zeros. lrck_o rises one bclk before the 0xABCDEF MSB. The bclk period is 4 clk.
- LJ 16-bit, bytes 80 01 7F FE -> lrck_o high for 32 bclk with 0x8001 MSB on the first bit, no delay; lrck_o low for the right slot 0x7FFE.
- TDM, CHANNELS=4, SLOT_BITS=32, 32-bit, 16 bytes -> lrck_o high exactly one bclk before slot 0 MSB; 128 bclk per frame; the frame-sync pulse repeats every 128 bclk.
- One frame supplied, then s_valid_i=0, IDLE_FRAMES=4 -> 4 zero frames each with an underrun_o pulse; DRAIN; streaming_o falls; bclk_o=1 and lrck_o=0 in IDLE.
- enable_i dropped mid-frame with the next frame complete -> the current frame finishes, DRAIN follows, and the pending frame is not sent; s_ready_o=0 from the drop.
- reset_n_i=0 for 1 clk at bit k=40 -> all outputs take their reset values on the next edge; a restart with fresh bytes produces a correctly aligned first frame.
